qsn_layer_scheduler: RTL and testbench

- Sequences the quasi-cyclic shift network (QSN) for a layered QC-LDPC decoder.
- Holds a programmable base-matrix shift table and walks it layer by layer for a configured number of iterations.
- Per row, issues a forward phase (read, shift s) then a writeback phase (inverse shift) for each non-null circulant, via a valid/ready command interface to the QSN datapath.

---
 rtl/qsn_layer_scheduler.sv | 165 ++++++++++++++++
 tb/tb_qsn_layer_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/qsn_layer_scheduler.sv
// Schedules the quasi-cyclic shift network of a layered QC-LDPC decoder.
// Walks a programmable shift table row by row: forward pass, then writeback pass.
module qsn_layer_scheduler #(
  parameter int LiftingFactor = 16,
  parameter int ShiftWidth    = 4,
  parameter int NumRows       = 4,
  parameter int NumCols       = 8,
  parameter int IterWidth     = 4,
  localparam int RowW = $clog2(NumRows),
  localparam int ColW = $clog2(NumCols)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [RowW-1:0]       cfg_row,
  input  logic [ColW-1:0]       cfg_col,
  input  logic                  cfg_valid,
  input  logic [ShiftWidth-1:0] cfg_shift,
  output logic                  cfg_err,
  input  logic                  start,
  input  logic [IterWidth-1:0]  num_iter,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ShiftWidth-1:0] cmd_shift,
  output logic [RowW-1:0]       cmd_row,
  output logic [ColW-1:0]       cmd_col,
  output logic                  cmd_phase,
  output logic                  cmd_last,
  output logic [IterWidth-1:0]  iter_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD, S_DONE} state_e;

  localparam logic [ShiftWidth:0] ZVal    = (ShiftWidth+1)'(LiftingFactor);
  localparam logic [RowW-1:0]     LastRow = RowW'(NumRows - 1);
  localparam logic [ColW-1:0]     LastCol = ColW'(NumCols - 1);

  state_e                state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [IterWidth-1:0]  iter_q, iter_d;
  logic [IterWidth-1:0]  num_iter_q, num_iter_d;
  logic                  cfg_err_q;

  logic [NumCols-1:0]    tbl_vld_q   [NumRows];
  logic [ShiftWidth-1:0] tbl_shift_q [NumRows][NumCols];

  logic                  in_scan;
  logic                  cur_vld;
  logic [ShiftWidth-1:0] cur_shift;
  logic [ShiftWidth-1:0] inv_shift;
  logic [NumCols-1:0]    higher_vld;
  logic                  advance;
  logic                  cfg_accept;
  logic [IterWidth-1:0]  iter_inc;

  assign in_scan    = (state_q == S_FWD) || (state_q == S_BWD);
  assign cur_vld    = tbl_vld_q[row_q][col_q];
  assign cur_shift  = tbl_shift_q[row_q][col_q];
  assign inv_shift  = (cur_shift == '0) ? '0 : ShiftWidth'(ZVal - {1'b0, cur_shift});
  // Entries strictly above the current column; empty means this is the last command.
  assign higher_vld = (tbl_vld_q[row_q] >> col_q) >> 1;
  // Null entries are skipped unconditionally; only real commands wait on the datapath.
  assign advance    = in_scan && (!cur_vld || cmd_ready);
  assign cfg_accept = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_shift} < ZVal);
  assign iter_inc   = iter_q + IterWidth'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      iter_q     <= '0;
      num_iter_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      iter_q     <= iter_d;
      num_iter_q <= num_iter_d;
      cfg_err_q  <= cfg_we && !cfg_accept;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NumRows; r++) begin
        tbl_vld_q[r] <= '0;
        for (int c = 0; c < NumCols; c++) tbl_shift_q[r][c] <= '0;
      end
    end else if (cfg_accept) begin
      tbl_vld_q[cfg_row][cfg_col]   <= cfg_valid;
      tbl_shift_q[cfg_row][cfg_col] <= cfg_shift;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    iter_d     = iter_q;
    num_iter_d = num_iter_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_iter_d = num_iter;
            row_d      = '0;
            col_d      = '0;
            iter_d     = '0;
            state_d    = (num_iter == '0) ? S_DONE : S_FWD;
          end
        end
        S_FWD, S_BWD: begin
          if (advance) begin
            if (col_q == LastCol) begin
              col_d = '0;
              if (state_q == S_FWD) begin
                state_d = S_BWD;
              end else if (row_q == LastRow) begin
                row_d   = '0;
                iter_d  = iter_inc;
                state_d = (iter_inc == num_iter_q) ? S_DONE : S_FWD;
              end else begin
                row_d   = row_q + RowW'(1);
                state_d = S_FWD;
              end
            end else begin
              col_d = col_q + ColW'(1);
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = in_scan;
    done      = (state_q == S_DONE);
    cfg_err   = cfg_err_q;
    iter_cnt  = iter_q;
    cmd_valid = in_scan && cur_vld;
    cmd_shift = '0;
    cmd_row   = '0;
    cmd_col   = '0;
    cmd_phase = 1'b0;
    cmd_last  = 1'b0;
    if (cmd_valid) begin
      cmd_phase = (state_q == S_BWD);
      cmd_shift = cmd_phase ? inv_shift : cur_shift;
      cmd_row   = row_q;
      cmd_col   = col_q;
      cmd_last  = (higher_vld == '0);
    end
  end

endmodule

// File: tb/tb_qsn_layer_scheduler.sv
// Directed bench for qsn_layer_scheduler: table programming, command order, stalls, abort.
module tb_qsn_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_row = '0;
  logic [2:0] cfg_col = '0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_shift = '0;
  logic       cfg_err;
  logic       start = 1'b0;
  logic [3:0] num_iter = '0;
  logic       abort = 1'b0;
  logic       busy, done, cmd_valid;
  logic       cmd_ready = 1'b1;
  logic [3:0] cmd_shift;
  logic [1:0] cmd_row;
  logic [2:0] cmd_col;
  logic       cmd_phase, cmd_last;
  logic [3:0] iter_cnt;

  int checks = 0;
  int failures = 0;
  int zero_viol = 0;
  int stall_n = 0;
  int done_at, ncmd, k;
  logic [14:0] cmdq[$];

  qsn_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_col(cfg_col), .cfg_valid(cfg_valid),
    .cfg_shift(cfg_shift), .cfg_err(cfg_err),
    .start(start), .num_iter(num_iter), .abort(abort),
    .busy(busy), .done(done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_shift(cmd_shift),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_phase(cmd_phase), .cmd_last(cmd_last),
    .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pk(input int it, input int r, input int c,
                                     input int s, input int ph, input int l);
    return {it[3:0], r[1:0], c[2:0], s[3:0], ph[0], l[0]};
  endfunction

  function automatic logic [14:0] cur_cmd();
    return {iter_cnt, cmd_row, cmd_col, cmd_shift, cmd_phase, cmd_last};
  endfunction

  task automatic wr(input int r, input int c, input int v, input int s);
    logic [31:0] t;
    t = r; cfg_row = t[1:0];
    t = c; cfg_col = t[2:0];
    t = v; cfg_valid = t[0];
    t = s; cfg_shift = t[3:0];
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts a schedule and runs until the done pulse; k=1 is the first busy cycle.
  task automatic run(input int n_iter, output int d_at, output int n);
    logic [14:0] snap;
    bit have_snap;
    logic [31:0] t;
    have_snap = 0;
    cmdq.delete();
    t = n_iter; num_iter = t[3:0];
    start = 1'b1;
    tick();
    start = 1'b0;
    d_at = -1;
    for (int kk = 1; kk <= 400; kk++) begin
      if (!cmd_valid && ({cmd_shift, cmd_row, cmd_col, cmd_phase, cmd_last} != '0))
        zero_viol++;
      if (cmd_valid && stall_n > 0) begin
        cmd_ready = 1'b0;
        if (have_snap) chk("stall_hold", cur_cmd(), snap);
        else begin snap = cur_cmd(); have_snap = 1; end
        stall_n--;
      end else begin
        cmd_ready = 1'b1;
        if (have_snap && cmd_valid) begin
          chk("stall_accept", cur_cmd(), snap);
          have_snap = 0;
        end
      end
      if (cmd_valid && cmd_ready) cmdq.push_back(cur_cmd());
      if (done) begin d_at = kk; break; end
      tick();
    end
    if (d_at < 0) chk("run_timeout", 0, 1);
    n = cmdq.size();
  endtask

  initial begin
    // Reset values
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_outs", {cfg_err, cmd_shift, cmd_row, cmd_col, cmd_phase, cmd_last, iter_cnt}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Empty table: 64 scan cycles, no commands, done at cycle 65
    run(1, done_at, ncmd);
    chk("empty_done_at", done_at, 65);
    chk("empty_ncmd", ncmd, 0);
    chk("empty_zero_outs", zero_viol, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    chk("after_done_pulse", done, 0);

    // Single entry, two iterations
    wr(1, 3, 1, 5);
    chk("legal_wr_no_err", cfg_err, 0);
    run(2, done_at, ncmd);
    chk("single_done_at", done_at, 129);
    chk("single_ncmd", ncmd, 4);
    if (ncmd == 4) begin
      chk("single_c0", cmdq[0], pk(0, 1, 3, 5, 0, 1));
      chk("single_c1", cmdq[1], pk(0, 1, 3, 11, 1, 1));
      chk("single_c2", cmdq[2], pk(1, 1, 3, 5, 0, 1));
      chk("single_c3", cmdq[3], pk(1, 1, 3, 11, 1, 1));
    end
    tick();
    chk("single_done_once", done, 0);

    // Mid-idle reset clears the table
    rst_n = 1'b0;
    #2;
    chk("async_rst_idle", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run(1, done_at, ncmd);
    chk("cleared_ncmd", ncmd, 0);
    tick();

    // Shift 0 and shift Z-1 at both ends of a row
    wr(0, 0, 1, 0);
    wr(0, 7, 1, 15);
    run(1, done_at, ncmd);
    chk("edge_done_at", done_at, 65);
    chk("edge_ncmd", ncmd, 4);
    if (ncmd == 4) begin
      chk("edge_c0", cmdq[0], pk(0, 0, 0, 0, 0, 0));
      chk("edge_c1", cmdq[1], pk(0, 0, 7, 15, 0, 1));
      chk("edge_c2", cmdq[2], pk(0, 0, 0, 0, 1, 0));
      chk("edge_c3", cmdq[3], pk(0, 0, 7, 1, 1, 1));
    end
    tick();

    // Backpressure: 3 stall cycles on the first command
    stall_n = 3;
    run(1, done_at, ncmd);
    chk("stall_done_at", done_at, 68);
    chk("stall_ncmd", ncmd, 4);
    if (ncmd > 0) chk("stall_c0", cmdq[0], pk(0, 0, 0, 0, 0, 0));
    tick();

    // Write while busy is rejected; abort returns to idle without done
    num_iter = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    wr(2, 2, 1, 5);
    chk("busy_wr_err", cfg_err, 1);
    tick();
    chk("err_one_cycle", cfg_err, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort1_busy", busy, 0);
    chk("abort1_done", done, 0);
    run(1, done_at, ncmd);
    chk("unchanged_ncmd", ncmd, 4);
    chk("unchanged_done_at", done_at, 65);
    tick();

    // Abort on a pending row-2 writeback command
    wr(2, 4, 1, 6);
    chk("idle_wr_no_err", cfg_err, 0);
    num_iter = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 1;
    while (k < 200 && !(cmd_valid && cmd_row == 2'd2 && cmd_phase)) begin
      tick();
      k++;
    end
    chk("row2_bwd_at", k, 45);
    chk("row2_bwd_cmd", cur_cmd(), pk(0, 2, 4, 10, 1, 1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cmd_valid", cmd_valid, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_no_late_done", done, 0);
    run(1, done_at, ncmd);
    chk("replay_done_at", done_at, 65);
    chk("replay_ncmd", ncmd, 6);
    if (ncmd == 6) begin
      chk("replay_c0", cmdq[0], pk(0, 0, 0, 0, 0, 0));
      chk("replay_c4", cmdq[4], pk(0, 2, 4, 6, 0, 1));
      chk("replay_c5", cmdq[5], pk(0, 2, 4, 10, 1, 1));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
